// File: rtl/risc_v_core_pkg.sv
// Shared core types: instruction names plus the atomic-sequencer state and AMO operation enums.
package risc_v_core_pkg;

   localparam int unsigned INSTR_W = 5;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned AMO_OP_W = 4;

   typedef enum logic [INSTR_W-1:0] {
      ADD, SUB, LW, SW,
      LR_W, SC_W,
      AMOSWAP, AMOADD, AMOAND, AMOOR, AMOXOR,
      AMOMAX, AMOMINI, AMOMAXU, AMOMINU
   } instr_name_t;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ, ST_DONE
   } amo_state_t;

   typedef enum logic [AMO_OP_W-1:0] {
      OP_SWAP, OP_ADD, OP_AND, OP_OR, OP_XOR,
      OP_MAX, OP_MIN, OP_MAXU, OP_MINU
   } amo_op_t;

   function automatic amo_op_t instr_to_amo_op(instr_name_t instr);
      amo_op_t op;
      op = OP_SWAP;
      case (instr)
         AMOSWAP: op = OP_SWAP;
         AMOADD:  op = OP_ADD;
         AMOAND:  op = OP_AND;
         AMOOR:   op = OP_OR;
         AMOXOR:  op = OP_XOR;
         AMOMAX:  op = OP_MAX;
         AMOMINI: op = OP_MIN;
         AMOMAXU: op = OP_MAXU;
         AMOMINU: op = OP_MINU;
         default: op = OP_SWAP;
      endcase
      return op;
   endfunction

   function automatic logic is_amo(instr_name_t instr);
      return (instr inside {AMOSWAP, AMOADD, AMOAND, AMOOR, AMOXOR,
                            AMOMAX, AMOMINI, AMOMAXU, AMOMINU});
   endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational modify step of an AMO: (op, old memory value, rs2) -> value to write back.
module amo_alu
   import risc_v_core_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  amo_op_t          op,
   input  logic [XLEN-1:0]  old_data,
   input  logic [XLEN-1:0]  rs2_data,
   output logic [XLEN-1:0]  new_data_c
);

   logic signed_gt;
   logic unsigned_gt;

   // On equal operands either choice yields the old value.
   always_comb begin
      signed_gt   = $signed(old_data) > $signed(rs2_data);
      unsigned_gt = old_data > rs2_data;
      new_data_c  = old_data;
      case (op)
         OP_SWAP: new_data_c = rs2_data;
         OP_ADD:  new_data_c = old_data + rs2_data;
         OP_AND:  new_data_c = old_data & rs2_data;
         OP_OR:   new_data_c = old_data | rs2_data;
         OP_XOR:  new_data_c = old_data ^ rs2_data;
         OP_MAX:  new_data_c = signed_gt   ? old_data : rs2_data;
         OP_MIN:  new_data_c = signed_gt   ? rs2_data : old_data;
         OP_MAXU: new_data_c = unsigned_gt ? old_data : rs2_data;
         OP_MINU: new_data_c = unsigned_gt ? rs2_data : old_data;
         default: new_data_c = old_data;
      endcase
   end

endmodule

// File: rtl/amo_sequencer.sv
// RV32A sequencer: runs LR.W / SC.W / AMO read-modify-write on the data-memory port
// and holds the single LR/SC reservation.
module amo_sequencer
   import risc_v_core_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  instr_name_t       instr_i,
   input  logic [XLEN-1:0]   rs1_data_i,
   input  logic [XLEN-1:0]   rs2_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [XLEN-1:0]   result_o,
   output logic              misaligned_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   input  logic              snoop_we_i,
   input  logic [ADDR_W-1:0] snoop_addr_i
);

   amo_state_t        state_q, state_d;
   instr_name_t       instr_q, instr_d;
   logic [XLEN-1:0]   rs2_q, rs2_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              res_valid_q, res_valid_d;
   logic [ADDR_W-1:0] res_addr_q, res_addr_d;

   logic              busy_d, done_d, misaligned_d, mem_req_d, mem_we_d;
   logic [XLEN-1:0]   result_out_d, mem_wdata_d;
   logic [ADDR_W-1:0] mem_addr_d;

   logic              snoop_hit_c;
   logic              sc_ok_c;
   amo_op_t           amo_op_c;
   logic [XLEN-1:0]   alu_new_c;

   assign amo_op_c    = instr_to_amo_op(instr_q);
   assign snoop_hit_c = snoop_we_i && ((snoop_addr_i >> 2) == (res_addr_q >> 2));
   assign sc_ok_c     = res_valid_q && (res_addr_q == ADDR_W'(rs1_data_i)) && !snoop_hit_c;

   amo_alu #(.XLEN(XLEN)) u_alu (
      .op         (amo_op_c),
      .old_data   (mem_rdata_i),
      .rs2_data   (rs2_q),
      .new_data_c (alu_new_c)
   );

   // Next state, datapath and registered-output values.
   always_comb begin
      state_d      = state_q;
      instr_d      = instr_q;
      rs2_d        = rs2_q;
      result_d     = result_q;
      res_valid_d  = res_valid_q;
      res_addr_d   = res_addr_q;
      mem_addr_d   = mem_addr_o;
      mem_wdata_d  = mem_wdata_o;
      misaligned_d = 1'b0;

      // Snoop clears first so an LR completing this cycle still installs its reservation.
      if (snoop_hit_c) res_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               instr_d    = instr_i;
               mem_addr_d = ADDR_W'(rs1_data_i);
               rs2_d      = rs2_data_i;
               if (rs1_data_i[1:0] != 2'b00) begin
                  misaligned_d = 1'b1;
               end else if (instr_i == LR_W || is_amo(instr_i)) begin
                  state_d = ST_RD_REQ;
               end else if (instr_i == SC_W) begin
                  res_valid_d = 1'b0;
                  mem_wdata_d = rs2_data_i;
                  if (sc_ok_c) begin
                     state_d = ST_WR_REQ;
                  end else begin
                     result_d = XLEN'(1);
                     state_d  = ST_DONE;
                  end
               end else begin
                  result_d = '0;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_RD_REQ: begin
            if (mem_gnt_i) state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (mem_rvalid_i) begin
               result_d = mem_rdata_i;
               if (instr_q == LR_W) begin
                  res_valid_d = 1'b1;
                  res_addr_d  = mem_addr_o;
                  state_d     = ST_DONE;
               end else begin
                  mem_wdata_d = alu_new_c;
                  state_d     = ST_WR_REQ;
               end
            end
         end
         ST_WR_REQ: begin
            if (mem_gnt_i) begin
               if (instr_q == SC_W) result_d = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d       = (state_d != ST_IDLE);
      mem_req_d    = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
      mem_we_d     = (state_d == ST_WR_REQ);
      done_d       = (state_q == ST_DONE);
      result_out_d = done_d ? result_q : result_o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         instr_q      <= instr_name_t'('0);
         rs2_q        <= '0;
         result_q     <= '0;
         res_valid_q  <= 1'b0;
         res_addr_q   <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         result_o     <= '0;
         misaligned_o <= 1'b0;
         mem_req_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
      end else begin
         state_q      <= state_d;
         instr_q      <= instr_d;
         rs2_q        <= rs2_d;
         result_q     <= result_d;
         res_valid_q  <= res_valid_d;
         res_addr_q   <= res_addr_d;
         busy_o       <= busy_d;
         done_o       <= done_d;
         result_o     <= result_out_d;
         misaligned_o <= misaligned_d;
         mem_req_o    <= mem_req_d;
         mem_we_o     <= mem_we_d;
         mem_addr_o   <= mem_addr_d;
         mem_wdata_o  <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed plus randomized bench for amo_sequencer against a transaction-level memory/reservation model.
module tb_amo_sequencer;
   import risc_v_core_pkg::*;
   timeunit 1ns;
   timeprecision 1ps;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   instr_name_t instr_i = ADD;
   logic [31:0] rs1_data_i = '0;
   logic [31:0] rs2_data_i = '0;
   logic        busy_o, done_o, misaligned_o, mem_req_o, mem_we_o;
   logic [31:0] result_o, mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        snoop_we_i = 1'b0;
   logic [31:0] snoop_addr_i = '0;

   amo_sequencer #(.ADDR_W(32), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .instr_i(instr_i),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .misaligned_o(misaligned_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .snoop_we_i(snoop_we_i), .snoop_addr_i(snoop_addr_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int gnt_wait = 0;
   int rv_wait  = 0;
   int n_rd = 0;
   int n_wr = 0;

   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   bit          ref_res_valid = 1'b0;
   logic [31:0] ref_res_addr = '0;
   logic [31:0] last_res;
   int          last_lat;

   function automatic logic [31:0] dflt(logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] mem_rd(logic [31:0] a);
      return mem.exists(a) ? mem[a] : dflt(a);
   endfunction

   function automatic logic [31:0] ref_rd(logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic bit tb_is_amo(instr_name_t ins);
      case (ins)
         AMOSWAP, AMOADD, AMOAND, AMOOR, AMOXOR, AMOMAX, AMOMINI, AMOMAXU, AMOMINU: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_new(instr_name_t ins, logic [31:0] old, logic [31:0] b);
      int so = old;
      int sb = b;
      case (ins)
         AMOSWAP: return b;
         AMOADD:  return old + b;
         AMOAND:  return old & b;
         AMOOR:   return old | b;
         AMOXOR:  return old ^ b;
         AMOMAX:  return (so > sb) ? old : b;
         AMOMINI: return (so < sb) ? old : b;
         AMOMAXU: return (old > b) ? old : b;
         AMOMINU: return (old < b) ? old : b;
         default: return old;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory slave: accepts at posedge, drives grant/rvalid at negedge with programmable waits.
   initial begin : slave
      bit          rd_pending = 1'b0;
      logic [31:0] rd_addr = '0;
      int          gcnt = 0;
      int          rcnt = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            rd_pending = 1'b0;
            gcnt = 0;
         end else if (mem_req_o && mem_gnt_i) begin
            if (mem_we_o) begin
               mem[mem_addr_o] = mem_wdata_o;
               n_wr++;
            end else begin
               rd_pending = 1'b1;
               rd_addr = mem_addr_o;
               rcnt = rv_wait;
               n_rd++;
            end
         end
         @(negedge clk);
         mem_gnt_i = 1'b0;
         mem_rvalid_i = 1'b0;
         if (rst_n) begin
            if (mem_req_o) begin
               if (gcnt >= gnt_wait) begin
                  mem_gnt_i = 1'b1;
                  gcnt = 0;
               end else gcnt++;
            end
            if (rd_pending) begin
               if (rcnt == 0) begin
                  mem_rvalid_i = 1'b1;
                  mem_rdata_i = mem_rd(rd_addr);
                  rd_pending = 1'b0;
               end else rcnt--;
            end
         end
      end
   end

   // One instruction end to end; called and returning on a negedge with the DUT idle.
   task automatic do_op(input instr_name_t ins, input logic [31:0] a, input logic [31:0] b,
                        input bit snp);
      logic [31:0] old, exp_res, exp_new;
      int exp_lat, exp_rd, exp_wr, rd0, wr0, lat, k, limit;
      bit exp_mis, got_mis, got_done, saw_req, busy_err, addr_err, wdata_err;
      exp_mis = (a[1:0] != 2'b00);
      exp_res = '0; exp_new = '0; exp_rd = 0; exp_wr = 0; exp_lat = 2;
      old = ref_rd(a);
      if (snp && ref_res_valid && ref_res_addr[31:2] == a[31:2]) ref_res_valid = 1'b0;
      if (exp_mis) begin
         exp_lat = 1;
      end else if (ins == LR_W) begin
         exp_res = old; exp_rd = 1; exp_lat = 4 + gnt_wait + rv_wait;
         ref_res_valid = 1'b1; ref_res_addr = a;
      end else if (ins == SC_W) begin
         if (ref_res_valid && ref_res_addr == a) begin
            exp_wr = 1; exp_new = b; exp_res = 0; exp_lat = 3 + gnt_wait;
            ref_mem[a] = b;
         end else begin
            exp_res = 1; exp_lat = 2;
         end
         ref_res_valid = 1'b0;
      end else if (tb_is_amo(ins)) begin
         exp_rd = 1; exp_wr = 1; exp_res = old;
         exp_new = model_new(ins, old, b); ref_mem[a] = exp_new;
         exp_lat = 5 + 2 * gnt_wait + rv_wait;
      end

      rd0 = n_rd; wr0 = n_wr;
      start_i = 1'b1; instr_i = ins; rs1_data_i = a; rs2_data_i = b;
      if (snp) begin snoop_we_i = 1'b1; snoop_addr_i = a; end
      got_mis = 0; got_done = 0; saw_req = 0; busy_err = 0; addr_err = 0; wdata_err = 0;
      lat = 0; k = 0;
      limit = exp_mis ? 4 : 80;
      while (k < limit && !got_done) begin
         @(negedge clk);
         k++;
         if (k == 1) begin start_i = 1'b0; snoop_we_i = 1'b0; end
         if (misaligned_o) got_mis = 1;
         if (!exp_mis && k < exp_lat && !busy_o) busy_err = 1;
         if (mem_req_o) begin
            saw_req = 1;
            if (mem_addr_o !== a) addr_err = 1;
            if (mem_we_o && mem_wdata_o !== exp_new) wdata_err = 1;
         end
         if (done_o) begin got_done = 1; lat = k; end
      end

      if (exp_mis) begin
         check("mis_pulse", 32'(got_mis), 32'd1);
         check("mis_no_done", 32'(got_done), 32'd0);
         check("mis_no_req", 32'(saw_req), 32'd0);
      end else begin
         check("done_seen", 32'(got_done), 32'd1);
         check("latency", 32'(lat), 32'(exp_lat));
         check("result", result_o, exp_res);
         check("busy_at_done", 32'(busy_o), 32'd0);
         check("busy_during", 32'(busy_err), 32'd0);
         last_res = result_o;
         last_lat = lat;
         @(negedge clk);
         check("done_one_cycle", 32'(done_o), 32'd0);
         check("result_held", result_o, exp_res);
      end
      check("reads", 32'(n_rd - rd0), 32'(exp_rd));
      check("writes", 32'(n_wr - wr0), 32'(exp_wr));
      check("addr_stable", 32'(addr_err), 32'd0);
      check("wdata_stable", 32'(wdata_err), 32'd0);
      if (!exp_mis) check("mem_word", mem_rd(a), ref_rd(a));
   endtask

   task automatic snoop(input logic [31:0] a);
      snoop_we_i = 1'b1; snoop_addr_i = a;
      if (ref_res_valid && ref_res_addr[31:2] == a[31:2]) ref_res_valid = 1'b0;
      @(negedge clk);
      snoop_we_i = 1'b0;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      instr_name_t amo_list [9] = '{AMOSWAP, AMOADD, AMOAND, AMOOR, AMOXOR,
                                    AMOMAX, AMOMINI, AMOMAXU, AMOMINU};
      logic [31:0] ra;
      int sel;

      repeat (3) @(negedge clk);
      check("rst_ctrl", {27'd0, busy_o, done_o, misaligned_o, mem_req_o, mem_we_o}, 32'd0);
      check("rst_result", result_o, 32'd0);
      check("rst_addr", mem_addr_o, 32'd0);
      check("rst_wdata", mem_wdata_o, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // AMOADD overflow wrap, zero-wait latency
      do_op(AMOSWAP, 32'h100, 32'h7FFF_FFFF, 0);
      do_op(AMOADD, 32'h100, 32'h1, 0);
      check("t1_res", last_res, 32'h7FFF_FFFF);
      check("t1_lat", 32'(last_lat), 32'd5);
      check("t1_mem", mem_rd(32'h100), 32'h8000_0000);

      // signed vs unsigned compare
      do_op(AMOSWAP, 32'h110, 32'hFFFF_FFFF, 0);
      do_op(AMOMAX, 32'h110, 32'h1, 0);
      check("t2_max", mem_rd(32'h110), 32'h1);
      do_op(AMOSWAP, 32'h110, 32'hFFFF_FFFF, 0);
      do_op(AMOMAXU, 32'h110, 32'h1, 0);
      check("t2_maxu", mem_rd(32'h110), 32'hFFFF_FFFF);
      do_op(AMOSWAP, 32'h110, 32'h8000_0000, 0);
      do_op(AMOMINI, 32'h110, 32'h0, 0);
      check("t2_min", mem_rd(32'h110), 32'h8000_0000);

      // LR/SC pair, then a stale SC
      do_op(AMOSWAP, 32'h200, 32'h55, 0);
      do_op(LR_W, 32'h200, 32'h0, 0);
      check("t3_lr", last_res, 32'h55);
      check("t3_lr_lat", 32'(last_lat), 32'd4);
      do_op(SC_W, 32'h200, 32'hAA, 0);
      check("t3_sc", last_res, 32'h0);
      check("t3_sc_lat", 32'(last_lat), 32'd3);
      check("t3_mem", mem_rd(32'h200), 32'hAA);
      do_op(SC_W, 32'h200, 32'hBB, 0);
      check("t3_sc2", last_res, 32'h1);
      check("t3_sc2_lat", 32'(last_lat), 32'd2);

      // snoop kills the reservation only on the same word
      do_op(LR_W, 32'h300, 32'h0, 0);
      snoop(32'h300);
      do_op(SC_W, 32'h300, 32'h11, 0);
      check("t4_sc_fail", last_res, 32'h1);
      do_op(LR_W, 32'h300, 32'h0, 0);
      snoop(32'h304);
      do_op(SC_W, 32'h300, 32'h22, 0);
      check("t4_sc_ok", last_res, 32'h0);
      do_op(LR_W, 32'h300, 32'h0, 0);
      do_op(SC_W, 32'h300, 32'h33, 1);
      check("t4_sc_same_cycle", last_res, 32'h1);

      // stalled grants and late read data
      gnt_wait = 3; rv_wait = 4;
      do_op(AMOSWAP, 32'h120, 32'h0F0F_1234, 0);
      do_op(AMOXOR, 32'h120, 32'hFFFF_0000, 0);
      check("t5_res", last_res, 32'h0F0F_1234);
      check("t5_mem", mem_rd(32'h120), 32'hF0F0_1234);
      gnt_wait = 0; rv_wait = 0;

      // misaligned abort, non-atomic no-op
      do_op(AMOSWAP, 32'h102, 32'h9, 0);
      do_op(ADD, 32'h100, 32'h9, 0);
      check("noop_res", last_res, 32'h0);

      // reset while waiting for read data
      do_op(LR_W, 32'h400, 32'h0, 0);
      rv_wait = 6;
      start_i = 1'b1; instr_i = AMOADD; rs1_data_i = 32'h400; rs2_data_i = 32'h5;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      check("rst_mid_busy", 32'(busy_o), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ctrl", {27'd0, busy_o, done_o, misaligned_o, mem_req_o, mem_we_o}, 32'd0);
      check("rst_mid_result", result_o, 32'd0);
      check("rst_mid_addr", mem_addr_o, 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("rst_mid_no_done", 32'(done_o), 32'd0);
      rst_n = 1'b1;
      ref_res_valid = 1'b0;
      rv_wait = 0;
      @(negedge clk);
      do_op(SC_W, 32'h400, 32'h77, 0);
      check("rst_sc_fail", last_res, 32'h1);

      // randomized mix
      for (int i = 0; i < 40; i++) begin
         gnt_wait = $urandom_range(0, 2);
         rv_wait  = $urandom_range(0, 2);
         ra  = 32'h100 + 32'(4 * $urandom_range(0, 7));
         sel = $urandom_range(0, 13);
         if ($urandom_range(0, 3) == 0) snoop(32'h100 + 32'(4 * $urandom_range(0, 7)));
         if (sel <= 8) do_op(amo_list[sel], ra, $urandom, 0);
         else if (sel == 9) do_op(LR_W, ra, 32'h0, 0);
         else if (sel == 10) do_op(SC_W, ra, $urandom, $urandom_range(0, 3) == 0);
         else if (sel == 11) begin
            do_op(LR_W, ra, 32'h0, 0);
            do_op(SC_W, ra, $urandom, $urandom_range(0, 3) == 0);
         end
         else if (sel == 12) do_op(SUB, ra, $urandom, 0);
         else do_op(AMOADD, ra | 32'(1 + $urandom_range(0, 2)), $urandom, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/amo_sequencer.md
Name: amo_sequencer

Overview:
- Multi-cycle controller that executes RV32A instructions: LR.W, SC.W and the nine AMO read-modify-write operations.
- Sits beside the execute stage. The decoder hands it an atomic instr_name plus operands, and it stalls the pipeline while it owns the data-memory port.
- It sequences the memory read, the internal modify and the memory write, and it holds the single LR/SC reservation.
- It returns the rd value with a one-cycle done pulse.

Parameters:
- ADDR_W, 32, data-memory address width.
- XLEN, 32, data width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  accept an atomic instruction; sampled only in IDLE
- instr_i  in  instr_name_t  decoded instruction name; must be an atomic enumerator
- rs1_data_i  in  XLEN  address operand
- rs2_data_i  in  XLEN  source operand
- busy_o  out  1  high in every state except IDLE; used as the pipeline stall
- done_o  out  1  one-cycle pulse: result_o is valid
- result_o  out  XLEN  value written to rd
- misaligned_o  out  1  one-cycle pulse: address not word-aligned, instruction aborted
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_W  word address (rs1_data_i captured at start)
- mem_wdata_o  out  XLEN  write data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid; arrives at least 1 cycle after the read grant
- mem_rdata_i  in  XLEN  read data
- snoop_we_i  in  1  another master, or a core store, wrote memory this cycle
- snoop_addr_i  in  ADDR_W  address of that write

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, reservation invalid, internal registers 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - start_i=1 captures instr, addr and rs2.
  - If addr[1:0]!=0: pulse misaligned_o, stay in IDLE, no memory access, reservation unchanged.
  - Else LR or AMO goes to RD_REQ.
  - Else SC with (reservation valid and res_addr==addr) goes to WR_REQ.
  - Else SC goes to DONE with result=1 and no memory access.
- RD_REQ: mem_req_o=1, mem_we_o=0. Hold request, address and write enable stable until mem_gnt_i, then go to RD_WAIT.
- RD_WAIT: on mem_rvalid_i, capture old=mem_rdata_i.
  - LR: set reservation valid, res_addr=addr, result=old, go to DONE.
  - AMO: result=old, compute new, go to WR_REQ.
- WR_REQ: mem_req_o=1, mem_we_o=1, mem_wdata_o = new (AMO) or rs2 (SC). Held stable until mem_gnt_i. On grant go to DONE; SC result=0.
- DONE: done_o=1 for one cycle, then IDLE. result_o is held until the next done.
- AMO modify rules, all 32-bit with wrap-around:
  - SWAP: new=rs2
  - ADD: new=old+rs2, carry dropped
  - AND / OR / XOR: bitwise
  - MAX / MINI: signed compare
  - MAXU / MINU: unsigned compare
  - Equal operands: new=old.
- Reservation rules:
  - Cleared by any SC leaving IDLE, successful or failed.
  - Cleared by snoop_we_i with snoop_addr_i[31:2]==res_addr[31:2] in any state. This includes the cycle an SC is evaluated in IDLE: the snoop wins and the SC fails.
  - An LR replaces any existing reservation.
  - Own AMO writes do not clear it unless reported on snoop.
- Latency with zero-wait memory (gnt in the request cycle, rvalid the next cycle), start at cycle 0:
  - AMO: done at cycle 5.
  - LR: done at cycle 4.
  - Successful SC: done at cycle 3.
  - Failed SC: done at cycle 2.
- start_i while busy is ignored; the pipeline guarantees it is held off by busy_o.
- Asynchronous reset mid-operation: immediate return to IDLE, mem_req_o drops, reservation cleared, no done pulse.
- Non-atomic instr_i with start_i: treated as a no-op. Go to DONE with result=0 and no memory access.

Decomposition:
- risc_v_core_pkg gains:
  - amo_state_t enum (the 5 states)
  - amo_op_t enum (SWAP, ADD, AND, OR, XOR, MAX, MIN, MAXU, MINU)
  - function instr_to_amo_op mapping the existing instr_name_t atomic enumerators (AMOSWAP…AMOMAXU, AMOMINI) onto amo_op_t
- One sub-module, amo_alu: purely combinational (op, old, rs2) -> new. It is verified standalone.

Test Plan:
1. AMOADD, rs1=0x100, mem[0x100]=0x7FFFFFFF, rs2=1, zero-wait memory -> result_o=0x7FFFFFFF, write 0x80000000 to 0x100, done at cycle 5, busy_o high on cycles 1-4.
2. AMOMAX mem=0xFFFFFFFF, rs2=0x00000001 -> writes 0x00000001. AMOMAXU on the same values -> writes 0xFFFFFFFF. AMOMINI mem=0x80000000, rs2=0 -> writes 0x80000000.
3. LR.W 0x200 (mem=0x55), then SC.W 0x200 rs2=0xAA -> LR result 0x55; SC writes 0xAA, result 0. A second SC.W 0x200 -> result 1, no mem_req_o.
4. LR.W 0x300, then snoop_we_i at 0x300 with the FSM in IDLE, then SC.W 0x300 -> result 1, no write. Repeat with snoop_addr 0x304 -> SC succeeds, result 0.
5. mem_gnt_i withheld for 3 cycles in RD_REQ and WR_REQ, rvalid delayed 4 cycles -> mem_addr_o, mem_we_o and mem_wdata_o stable while waiting, exactly one read and one write, correct result.
6. AMOSWAP at 0x102 -> misaligned_o pulse, no mem_req_o, no done_o. Assert rst_n low while in RD_WAIT -> all outputs 0 next edge, reservation lost (a following SC fails).
